// File: rtl/csr_pkg.sv
`default_nettype none
// csr_pkg: CSR addresses, op/privilege encodings, mstatus bit positions and interrupt codes.
package csr_pkg;
  localparam logic [11:0] ADDR_SSTATUS  = 12'h100;
  localparam logic [11:0] ADDR_STVEC    = 12'h105;
  localparam logic [11:0] ADDR_SSCRATCH = 12'h140;
  localparam logic [11:0] ADDR_SEPC     = 12'h141;
  localparam logic [11:0] ADDR_SCAUSE   = 12'h142;
  localparam logic [11:0] ADDR_STVAL    = 12'h143;
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MEDELEG  = 12'h302;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  localparam int MSTATUS_SIE    = 1;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_SPIE   = 5;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_SPP    = 8;
  localparam int MSTATUS_MPP_LO = 11;

  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;
endpackage
`default_nettype wire

// File: rtl/csr_counter.sv
`default_nettype none
// csr_counter: free-running counter with increment enable; a write overrides the increment.
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_i)       count_d = wdata_i;
    else if (inc_i) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// csr_unit: M/S CSR file with privilege checks, trap entry/delegation, xRET,
// interrupt prioritisation and cycle/instret counters; redirects are registered pulses.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter bit          HAS_SMODE  = 1'b1,
  parameter logic [63:0] HART_ID    = 64'd0,
  parameter logic [63:0] MISA_VALUE = 64'h8000_0000_0014_1101
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [11:0]     CSR_ADDR,
  input  logic [1:0]      CSR_OP,
  input  logic [XLEN-1:0] CSR_WDATA,
  output logic [XLEN-1:0] CSR_RDATA,
  output logic            CSR_ILLEGAL,
  input  logic            TRAP,
  input  logic [XLEN-1:0] TRAP_CAUSE,
  input  logic [XLEN-1:0] TRAP_PC,
  input  logic [XLEN-1:0] TRAP_TVAL,
  input  logic            MRET,
  input  logic            SRET,
  input  logic            INSTR_RETIRED,
  input  logic            IRQ_EXT,
  input  logic            IRQ_TIMER,
  input  logic            IRQ_SW,
  output logic            INT_PENDING,
  output logic [XLEN-1:0] INT_CAUSE,
  output logic            REDIRECT,
  output logic [XLEN-1:0] REDIRECT_PC,
  output logic [1:0]      PRIVILEGE
);
  localparam int              IDXW         = $clog2(XLEN);
  localparam logic [XLEN-1:0] SSTATUS_MASK = XLEN'(12'h122);
  localparam logic [XLEN-1:0] MIE_MASK     = XLEN'(12'h888);
  localparam logic [XLEN-1:0] EPC_MASK     = ~XLEN'(3);
  localparam logic [XLEN-1:0] TVEC_MASK    = ~XLEN'(2);

  logic [1:0] priv_q, priv_d, mpp_q, mpp_d;
  logic sie_q, sie_d, mie_q, mie_d, spie_q, spie_d, mpie_q, mpie_d, spp_q, spp_d;
  logic [XLEN-1:0] medeleg_q, medeleg_d, mie_reg_q, mie_reg_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] stvec_q, stvec_d, sscratch_q, sscratch_d, sepc_q, sepc_d;
  logic [XLEN-1:0] scause_q, scause_d, stval_q, stval_d;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic [XLEN-1:0] mstatus_rd, mip_rd, pend, rdata, wval, mcycle, minstret;
  logic [XLEN-1:0] tvec, trap_target, redirect_target;
  logic [XLEN-2:0] trap_code;
  logic            hit, op_act, acc_illegal, mret_illegal, sret_illegal;
  logic            mret_fire, sret_fire, csr_we, deleg, mcycle_we, minstret_we;
  csr_op_e         op;

  assign op = csr_op_e'(CSR_OP);

  always_comb begin
    mstatus_rd                        = '0;
    mstatus_rd[MSTATUS_SIE]           = sie_q;
    mstatus_rd[MSTATUS_MIE]           = mie_q;
    mstatus_rd[MSTATUS_SPIE]          = spie_q;
    mstatus_rd[MSTATUS_MPIE]          = mpie_q;
    mstatus_rd[MSTATUS_SPP]           = spp_q;
    mstatus_rd[MSTATUS_MPP_LO +: 2]   = mpp_q;
    mip_rd                            = '0;
    mip_rd[IRQ_MEI]                   = IRQ_EXT;
    mip_rd[IRQ_MTI]                   = IRQ_TIMER;
    mip_rd[IRQ_MSI]                   = IRQ_SW;
  end

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (CSR_ADDR)
      ADDR_MSTATUS:  rdata = mstatus_rd;
      ADDR_MISA:     rdata = MISA_VALUE[XLEN-1:0];
      ADDR_MEDELEG:  rdata = medeleg_q;
      ADDR_MIE:      rdata = mie_reg_q;
      ADDR_MTVEC:    rdata = mtvec_q;
      ADDR_MSCRATCH: rdata = mscratch_q;
      ADDR_MEPC:     rdata = mepc_q;
      ADDR_MCAUSE:   rdata = mcause_q;
      ADDR_MTVAL:    rdata = mtval_q;
      ADDR_MIP:      rdata = mip_rd;
      ADDR_MCYCLE, ADDR_CYCLE:     rdata = mcycle;
      ADDR_MINSTRET, ADDR_INSTRET: rdata = minstret;
      ADDR_MHARTID:  rdata = HART_ID[XLEN-1:0];
      ADDR_SSTATUS:  if (HAS_SMODE) rdata = mstatus_rd & SSTATUS_MASK; else hit = 1'b0;
      ADDR_STVEC:    if (HAS_SMODE) rdata = stvec_q;    else hit = 1'b0;
      ADDR_SSCRATCH: if (HAS_SMODE) rdata = sscratch_q; else hit = 1'b0;
      ADDR_SEPC:     if (HAS_SMODE) rdata = sepc_q;     else hit = 1'b0;
      ADDR_SCAUSE:   if (HAS_SMODE) rdata = scause_q;   else hit = 1'b0;
      ADDR_STVAL:    if (HAS_SMODE) rdata = stval_q;    else hit = 1'b0;
      default:       hit = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_WRITE: wval = CSR_WDATA;
      OP_SET:   wval = rdata | CSR_WDATA;
      OP_CLEAR: wval = rdata & ~CSR_WDATA;
      default:  wval = rdata;
    endcase
  end

  assign op_act       = (op != OP_NONE);
  assign acc_illegal  = op_act && (!hit || (CSR_ADDR[9:8] > priv_q) || (CSR_ADDR[11:10] == 2'b11));
  assign mret_illegal = MRET && (priv_q != PRIV_M);
  assign sret_illegal = SRET && (!HAS_SMODE || (priv_q == PRIV_U));
  assign CSR_ILLEGAL  = acc_illegal || mret_illegal || sret_illegal;

  // One event per cycle: TRAP > MRET > SRET > CSR write; an asserted but illegal xRET still blocks.
  assign mret_fire   = !TRAP && MRET && !mret_illegal;
  assign sret_fire   = !TRAP && !MRET && SRET && !sret_illegal;
  assign csr_we      = !TRAP && !MRET && !SRET && op_act && !acc_illegal;
  assign mcycle_we   = csr_we && (CSR_ADDR == ADDR_MCYCLE);
  assign minstret_we = csr_we && (CSR_ADDR == ADDR_MINSTRET);

  assign trap_code = TRAP_CAUSE[XLEN-2:0];
  assign deleg = HAS_SMODE && (priv_q != PRIV_M) && !TRAP_CAUSE[XLEN-1]
              && !(|trap_code[XLEN-2:IDXW]) && medeleg_q[trap_code[IDXW-1:0]];

  always_comb begin
    tvec        = deleg ? stvec_q : mtvec_q;
    trap_target = {tvec[XLEN-1:2], 2'b00};
    if (tvec[0] && TRAP_CAUSE[XLEN-1])
      trap_target = trap_target + {TRAP_CAUSE[XLEN-3:0], 2'b00};
    redirect_target = TRAP ? trap_target : (mret_fire ? mepc_q : sepc_q);
  end

  always_comb begin
    priv_d = priv_q;   mpp_d = mpp_q;   sie_d = sie_q;   mie_d = mie_q;
    spie_d = spie_q;   mpie_d = mpie_q; spp_d = spp_q;
    medeleg_d = medeleg_q; mie_reg_d = mie_reg_q; mtvec_d = mtvec_q;
    mscratch_d = mscratch_q; mepc_d = mepc_q; mcause_d = mcause_q; mtval_d = mtval_q;
    stvec_d = stvec_q; sscratch_d = sscratch_q; sepc_d = sepc_q;
    scause_d = scause_q; stval_d = stval_q;
    if (TRAP) begin
      if (deleg) begin
        scause_d = TRAP_CAUSE; sepc_d = TRAP_PC & EPC_MASK; stval_d = TRAP_TVAL;
        spie_d = sie_q; sie_d = 1'b0; spp_d = priv_q[0]; priv_d = PRIV_S;
      end else begin
        mcause_d = TRAP_CAUSE; mepc_d = TRAP_PC & EPC_MASK; mtval_d = TRAP_TVAL;
        mpie_d = mie_q; mie_d = 1'b0; mpp_d = priv_q; priv_d = PRIV_M;
      end
    end else if (mret_fire) begin
      mie_d = mpie_q; mpie_d = 1'b1; priv_d = mpp_q; mpp_d = PRIV_U;
    end else if (sret_fire) begin
      sie_d = spie_q; spie_d = 1'b1; priv_d = {1'b0, spp_q}; spp_d = 1'b0;
    end else if (csr_we) begin
      case (CSR_ADDR)
        ADDR_MSTATUS: begin
          sie_d  = wval[MSTATUS_SIE];  mie_d  = wval[MSTATUS_MIE];
          spie_d = wval[MSTATUS_SPIE]; mpie_d = wval[MSTATUS_MPIE];
          spp_d  = wval[MSTATUS_SPP];
          mpp_d  = (wval[MSTATUS_MPP_LO +: 2] == 2'b10) ? 2'b00 : wval[MSTATUS_MPP_LO +: 2];
        end
        ADDR_SSTATUS: begin
          sie_d = wval[MSTATUS_SIE]; spie_d = wval[MSTATUS_SPIE]; spp_d = wval[MSTATUS_SPP];
        end
        ADDR_MEDELEG:  medeleg_d  = wval;
        ADDR_MIE:      mie_reg_d  = wval & MIE_MASK;
        ADDR_MTVEC:    mtvec_d    = wval & TVEC_MASK;
        ADDR_MSCRATCH: mscratch_d = wval;
        ADDR_MEPC:     mepc_d     = wval & EPC_MASK;
        ADDR_MCAUSE:   mcause_d   = wval;
        ADDR_MTVAL:    mtval_d    = wval;
        ADDR_STVEC:    stvec_d    = wval & TVEC_MASK;
        ADDR_SSCRATCH: sscratch_d = wval;
        ADDR_SEPC:     sepc_d     = wval & EPC_MASK;
        ADDR_SCAUSE:   scause_d   = wval;
        ADDR_STVAL:    stval_d    = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      priv_q <= PRIV_M; mpp_q <= 2'b00; sie_q <= 1'b0; mie_q <= 1'b0;
      spie_q <= 1'b0; mpie_q <= 1'b0; spp_q <= 1'b0;
      medeleg_q <= '0; mie_reg_q <= '0; mtvec_q <= '0; mscratch_q <= '0;
      mepc_q <= '0; mcause_q <= '0; mtval_q <= '0; stvec_q <= '0;
      sscratch_q <= '0; sepc_q <= '0; scause_q <= '0; stval_q <= '0;
      redirect_q <= 1'b0; redirect_pc_q <= '0;
    end else begin
      priv_q <= priv_d; mpp_q <= mpp_d; sie_q <= sie_d; mie_q <= mie_d;
      spie_q <= spie_d; mpie_q <= mpie_d; spp_q <= spp_d;
      medeleg_q <= medeleg_d; mie_reg_q <= mie_reg_d; mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d; mepc_q <= mepc_d; mcause_q <= mcause_d; mtval_q <= mtval_d;
      stvec_q <= stvec_d; sscratch_q <= sscratch_d; sepc_q <= sepc_d;
      scause_q <= scause_d; stval_q <= stval_d;
      redirect_q <= TRAP || mret_fire || sret_fire;
      if (TRAP || mret_fire || sret_fire) redirect_pc_q <= redirect_target;
    end
  end

  csr_counter #(.WIDTH(XLEN)) u_mcycle (
    .clk_i(CLK), .rst_i(RESET), .inc_i(1'b1), .wr_i(mcycle_we),
    .wdata_i(wval), .count_o(mcycle)
  );

  csr_counter #(.WIDTH(XLEN)) u_minstret (
    .clk_i(CLK), .rst_i(RESET), .inc_i(INSTR_RETIRED), .wr_i(minstret_we),
    .wdata_i(wval), .count_o(minstret)
  );

  // Fixed priority MEI > MSI > MTI; the cause is reported even when globally masked.
  assign pend        = mip_rd & mie_reg_q;
  assign INT_PENDING = (|pend) && ((priv_q != PRIV_M) || mie_q);
  always_comb begin
    if (pend[IRQ_MEI])      INT_CAUSE = {1'b1, (XLEN-1)'(IRQ_MEI)};
    else if (pend[IRQ_MSI]) INT_CAUSE = {1'b1, (XLEN-1)'(IRQ_MSI)};
    else if (pend[IRQ_MTI]) INT_CAUSE = {1'b1, (XLEN-1)'(IRQ_MTI)};
    else                    INT_CAUSE = '0;
  end

  assign CSR_RDATA   = rdata;
  assign REDIRECT    = redirect_q;
  assign REDIRECT_PC = redirect_pc_q;
  assign PRIVILEGE   = priv_q;
endmodule
`default_nettype wire
